gmii_tx_arbiter: RTL and testbench
==================================

// Module: gmii_tx_arbiter
// PURPOSE
//  Frame-level round-robin arbiter sharing the single GMII TX byte stream (into the RGMII TX frame buffer) between
//  N stack requesters (e.g. ARP, ICMP, UDP). Grants one requester at a time, muxes its bytes onto o_gmii_tx_data/valid,
//  enforces a minimum idle gap after every frame so the downstream buffer sees a clean valid falling edge
//  (length commit), and caps frames at the buffer depth.
// PARAMETERS
//  N_REQ     3     number of requesters, 2..8
//  MAX_LEN   1526  max bytes per frame (TX RAM depth)
//  IFG_CYC   12    idle cycles forced on o_gmii_tx_valid after each frame, >=2
//  WDOG_CYC  64    grant-to-first-byte timeout (ARB_WDOG_EN only)
// PORTS
//  i_udp_stack_clk    in   1          stack clock, all logic on rising edge
//  i_udp_stack_rst_n  in   1          asynchronous active-low reset
//  i_req              in   N_REQ      per-requester frame request, level, held until its last byte
//  o_grant            out  N_REQ      one-hot grant, registered
//  i_req_data         in   N_REQ*8    packed bytes, requester k at [8k+7:8k]
//  i_req_valid        in   N_REQ      byte valid, contiguous for the whole frame
//  i_req_last         in   N_REQ      marks final byte (qualified by valid)
//  o_gmii_tx_data     out  8          muxed byte to TX frame buffer
//  o_gmii_tx_valid    out  1          muxed valid
//  o_err_oversize     out  1          1-cycle pulse: frame truncated at MAX_LEN
//  o_err_underrun     out  1          1-cycle pulse: valid dropped before last
//  o_busy             out  1          high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, counters 0. Reset mid-frame aborts immediately, no pulses.
//  FSM: IDLE -> GRANT -> XFER -> IFG -> IDLE; XFER -> DRAIN -> IFG on oversize.
//  IDLE: if any i_req, pick first set bit searching from rr pointer upward (wrap at N_REQ); o_grant set next cycle; ->GRANT.
//  GRANT: wait for i_req_valid[g]. If i_req[g] drops first -> IDLE, grant cleared, rr pointer unchanged.
//  XFER: o_gmii_tx_data/valid = registered copy of requester g, latency 1 cycle. 11-bit byte counter increments per valid.
//   valid&last -> IFG; rr pointer <= g+1 (mod N_REQ).
//   valid=0 before last -> o_err_underrun pulse, frame ends there, -> IFG.
//   byte MAX_LEN forwarded without last -> o_err_oversize pulse, -> DRAIN.
//  DRAIN: o_gmii_tx_valid=0; bytes of g discarded until valid&last, then -> IFG.
//  IFG: o_grant=0, o_gmii_tx_valid=0 for IFG_CYC cycles, then IDLE. Requests raised meanwhile wait.
//  Grant is released the cycle after last is accepted; the requester must not drive valid without grant (ignored).
//  Non-granted requesters' data/valid are ignored at all times. o_gmii_tx_data is 0 whenever valid=0.
//  Simultaneous requests: rr pointer decides; a just-served requester is lowest priority next round.
//  Single-byte frame (valid&last on first byte) is legal: 1 byte out, then IFG.
// CONFIGURATION
//  ARB_WDOG_EN defined: in GRANT, counter runs; reaching WDOG_CYC without valid -> grant revoked, rr pointer advances past g,
//   -> IFG. Not defined: GRANT waits indefinitely (only req drop exits); WDOG_CYC unused.
// TESTING
//  1. req[2] only, 60-byte frame 0x00..0x3B -> grant=3'b100 one cycle later; output same bytes 1 cycle delayed; 12 idle cycles.
//  2. req=3'b111 at once, 10-byte frames each -> served order 0,1,2; >=12 idle cycles between frames; no overlap.
//  3. req[0] sends 1600 bytes, no last until byte 1600 -> exactly 1526 bytes out, o_err_oversize pulse once, DRAIN till last.
//  4. req[1] drops valid after byte 20 of 40 -> 20 bytes out, o_err_underrun pulse, next grant only after IFG.
//  5. Reset asserted at byte 100 of a frame -> outputs 0 asynchronously; after release, new req[0] frame served normally.
//  6. ARB_WDOG_EN: grant req[1], no valid for 64 cycles -> grant cleared, req[2] pending served next after IFG.

Source files
------------

// File: rtl/gmii_tx_arbiter_if.sv
// Requester-side and GMII-side signal bundle for gmii_tx_arbiter.
interface gmii_tx_arbiter_if #(
    parameter int N_REQ = 3
) ();
    logic [N_REQ-1:0]   i_req;
    logic [N_REQ-1:0]   o_grant;
    logic [N_REQ*8-1:0] i_req_data;
    logic [N_REQ-1:0]   i_req_valid;
    logic [N_REQ-1:0]   i_req_last;
    logic [7:0]         o_gmii_tx_data;
    logic               o_gmii_tx_valid;
    logic               o_err_oversize;
    logic               o_err_underrun;
    logic               o_busy;

    modport slave (
        input  i_req, i_req_data, i_req_valid, i_req_last,
        output o_grant, o_gmii_tx_data, o_gmii_tx_valid, o_err_oversize, o_err_underrun, o_busy
    );

    modport master (
        output i_req, i_req_data, i_req_valid, i_req_last,
        input  o_grant, o_gmii_tx_data, o_gmii_tx_valid, o_err_oversize, o_err_underrun, o_busy
    );
endinterface

// File: rtl/gmii_tx_arbiter.sv
// Frame-level round-robin arbiter muxing N_REQ byte streams onto one GMII TX stream with forced IFG.
// Optional `ARB_WDOG_EN: revoke a grant that never produces a first byte within WDOG_CYC cycles.
module gmii_tx_arbiter #(
    parameter int N_REQ    = 3,
    parameter int MAX_LEN  = 1526,
    parameter int IFG_CYC  = 12,
    parameter int WDOG_CYC = 64
) (
    input  logic            i_udp_stack_clk,
    input  logic            i_udp_stack_rst_n,
    gmii_tx_arbiter_if.slave io_bus
);
    localparam int IDX_W   = $clog2(N_REQ);
    localparam int CNT_W   = 11;
    // One timer serves both the IFG countdown and the grant watchdog.
    localparam int TMR_MAX = (IFG_CYC > WDOG_CYC) ? IFG_CYC : WDOG_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_XFER,
        S_DRAIN,
        S_IFG
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_rr, w_rr_nxt;
    logic [IDX_W-1:0] r_gidx, w_gidx_nxt;
    logic [IDX_W-1:0] w_pick, w_rr_adv;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    logic [7:0]       r_tx_data, w_tx_data_nxt, w_sel_data;
    logic             r_tx_valid, w_tx_valid_nxt;
    logic             r_err_ov, w_err_ov_nxt;
    logic             r_err_un, w_err_un_nxt;
    logic             w_sel_req, w_sel_valid, w_sel_last;
    logic             w_any_req, w_end;

    assign w_sel_req   = io_bus.i_req[r_gidx];
    assign w_sel_valid = io_bus.i_req_valid[r_gidx];
    assign w_sel_last  = io_bus.i_req_last[r_gidx];
    assign w_sel_data  = io_bus.i_req_data[{r_gidx, 3'b000} +: 8];
    assign w_any_req   = |io_bus.i_req;
    assign w_rr_adv    = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
    assign w_cnt_inc   = (r_state == S_GRANT) ? CNT_W'(1) : r_cnt + 1'b1;

    // Walk downward so the requester closest to the rr pointer is written last and wins.
    always_comb begin
        int idx;
        w_pick = r_rr;
        idx    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = int'(r_rr) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (io_bus.i_req[idx]) w_pick = IDX_W'(idx);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_rr_nxt       = r_rr;
        w_gidx_nxt     = r_gidx;
        w_grant_nxt    = r_grant;
        w_cnt_nxt      = r_cnt;
        w_tmr_nxt      = r_tmr;
        w_tx_valid_nxt = 1'b0;
        w_tx_data_nxt  = '0;
        w_err_ov_nxt   = 1'b0;
        w_err_un_nxt   = 1'b0;
        w_end          = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_gidx_nxt  = w_pick;
                    w_grant_nxt = N_REQ'(1) << w_pick;
                    w_cnt_nxt   = '0;
                    w_tmr_nxt   = '0;
                end
            end
            S_GRANT, S_XFER: begin
                if (w_sel_valid) begin
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = w_sel_data;
                    w_cnt_nxt      = w_cnt_inc;
                    if (w_sel_last) begin
                        w_end = 1'b1;
                    end else if (w_cnt_inc == CNT_W'(MAX_LEN)) begin
                        w_err_ov_nxt = 1'b1;
                        w_state_nxt  = S_DRAIN;
                    end else begin
                        w_state_nxt = S_XFER;
                    end
                end else if (r_state == S_XFER) begin
                    w_err_un_nxt = 1'b1;
                    w_end        = 1'b1;
                end else if (!w_sel_req) begin
                    // Requester withdrew before its first byte: no frame, pointer stays.
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                end
`ifdef ARB_WDOG_EN
                else if (r_tmr == TMR_W'(WDOG_CYC - 1)) begin
                    w_end = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
`endif
            end
            S_DRAIN: begin
                if (w_sel_valid && w_sel_last) w_end = 1'b1;
            end
            S_IFG: begin
                if (r_tmr == TMR_W'(IFG_CYC - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Every way out of a granted frame lands in IFG with the requester demoted.
        if (w_end) begin
            w_state_nxt = S_IFG;
            w_grant_nxt = '0;
            w_rr_nxt    = w_rr_adv;
            w_tmr_nxt   = '0;
        end
    end

    always_ff @(posedge i_udp_stack_clk or negedge i_udp_stack_rst_n) begin
        if (!i_udp_stack_rst_n) begin
            r_state    <= S_IDLE;
            r_rr       <= '0;
            r_gidx     <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_tmr      <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_err_ov   <= 1'b0;
            r_err_un   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_gidx     <= w_gidx_nxt;
            r_grant    <= w_grant_nxt;
            r_cnt      <= w_cnt_nxt;
            r_tmr      <= w_tmr_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_err_ov   <= w_err_ov_nxt;
            r_err_un   <= w_err_un_nxt;
        end
    end

    assign io_bus.o_grant         = r_grant;
    assign io_bus.o_gmii_tx_data  = r_tx_data;
    assign io_bus.o_gmii_tx_valid = r_tx_valid;
    assign io_bus.o_err_oversize  = r_err_ov;
    assign io_bus.o_err_underrun  = r_err_un;
    assign io_bus.o_busy          = (r_state != S_IDLE);
endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Scoreboard bench for gmii_tx_arbiter: round-robin order model feeds byte/grant queues, a monitor checks the DUT.
module tb_gmii_tx_arbiter;
    localparam int N_REQ    = 3;
    localparam int MAX_LEN  = 1526;
    localparam int IFG_CYC  = 12;
    localparam int WDOG_CYC = 64;

    localparam int M_NORM  = 0;
    localparam int M_UNDER = 1;
    localparam int M_ABORT = 2;
    localparam int M_OVER  = 3;
    localparam int M_STALL = 4;

    localparam int ST_WAIT = 0;
    localparam int ST_SEND = 1;
    localparam int ST_DONE = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gmii_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    gmii_tx_arbiter #(
        .N_REQ(N_REQ), .MAX_LEN(MAX_LEN), .IFG_CYC(IFG_CYC), .WDOG_CYC(WDOG_CYC)
    ) dut (
        .i_udp_stack_clk  (clk),
        .i_udp_stack_rst_n(rst_n),
        .io_bus           (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    int exp_g_q[$];
    int mon_ov = 0;
    int mon_un = 0;
    int rr_m   = 0;
    int n_over = 0;
    int ph_mode[N_REQ];
    int ph_len[N_REQ];
    int ph_und[N_REQ];
    int ph_base[N_REQ];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_frame(input int k, input int m, input int l, input int u, input int b);
        ph_mode[k] = m; ph_len[k] = l; ph_und[k] = u; ph_base[k] = b;
    endtask

    task automatic zero_inputs();
        bus.i_req = '0; bus.i_req_valid = '0; bus.i_req_last = '0; bus.i_req_data = '0;
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while (bus.o_busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (n >= lim) chk("idle_timeout", bus.o_busy, 0);
        @(negedge clk);
    endtask

    // Monitor: pops expected bytes/grants whenever the DUT presents them.
    initial begin : monitor
        logic prev_v = 1'b0;
        logic [N_REQ-1:0] prev_g = '0;
        int idle = 0;
        bit have = 1'b0;
        logic [7:0] e;
        int k;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0; prev_g = '0; have = 1'b0; idle = 0;
                continue;
            end
            if (bus.o_gmii_tx_valid) begin
                if (!prev_v && have) chk("ifg_gap", (idle >= IFG_CYC) ? IFG_CYC : idle, IFG_CYC);
                if (exp_q.size() == 0) chk("unexpected_byte", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("tx_data", bus.o_gmii_tx_data, e);
                end
                have = 1'b1;
                idle = 0;
            end else begin
                chk("idle_data_zero", bus.o_gmii_tx_data, 0);
                idle++;
            end
            prev_v = bus.o_gmii_tx_valid;
            if (bus.o_err_oversize) mon_ov++;
            if (bus.o_err_underrun) mon_un++;
            chk("grant_onehot0", $onehot0(bus.o_grant), 1);
            if (bus.o_grant != '0 && prev_g == '0) begin
                if (exp_g_q.size() == 0) chk("unexpected_grant", bus.o_grant, 0);
                else begin
                    k = exp_g_q.pop_front();
                    chk("grant_order", bus.o_grant, 1 << k);
                end
            end
            prev_g = bus.o_grant;
        end
    end

    // One arbitration round: all masked requesters raise req together while the DUT is idle.
    task automatic run_phase(input logic [N_REQ-1:0] mask, input bit noise, input int rst_at);
        int order[$];
        int st[N_REQ];
        int idx[N_REQ];
        bit seen[N_REQ];
        int exp_ov = 0, exp_un = 0, budget = 200, first_iter = -1, nb;
        logic [N_REQ-1:0] g, first_g = '0;
        bit all_done;

        for (int i = 0; i < N_REQ; i++) if (mask[(rr_m + i) % N_REQ]) order.push_back((rr_m + i) % N_REQ);
        foreach (order[j]) begin
            int k = order[j];
            exp_g_q.push_back(k);
            budget += ph_len[k] + IFG_CYC + WDOG_CYC + 10;
            case (ph_mode[k])
                M_NORM:  begin for (int b = 0; b < ph_len[k]; b++) exp_q.push_back(8'(ph_base[k] + b)); rr_m = (k + 1) % N_REQ; end
                M_UNDER: begin for (int b = 0; b < ph_und[k]; b++) exp_q.push_back(8'(ph_base[k] + b)); exp_un++; rr_m = (k + 1) % N_REQ; end
                M_OVER:  begin for (int b = 0; b < MAX_LEN; b++) exp_q.push_back(8'(ph_base[k] + b)); exp_ov++; rr_m = (k + 1) % N_REQ; end
                M_STALL: rr_m = (k + 1) % N_REQ;
                default: ;
            endcase
        end
        mon_ov = 0;
        mon_un = 0;
        for (int k = 0; k < N_REQ; k++) begin
            st[k] = mask[k] ? ST_WAIT : ST_DONE; idx[k] = 0; seen[k] = 1'b0;
        end

        all_done = 1'b0;
        for (int it = 0; it < budget && !all_done; it++) begin
            @(posedge clk); #1;
            g = bus.o_grant;
            if (first_iter < 0 && g != '0) begin first_iter = it; first_g = g; end
            for (int k = 0; k < N_REQ; k++) begin
                if (st[k] == ST_WAIT) begin
                    bus.i_req[k] = 1'b1;
                    bus.i_req_valid[k] = noise ? 1'($urandom) : 1'b0;
                    bus.i_req_last[k]  = noise ? 1'($urandom) : 1'b0;
                    bus.i_req_data[k*8 +: 8] = noise ? 8'($urandom) : 8'h00;
                    if (ph_mode[k] == M_STALL && seen[k] && !g[k]) begin
                        zero_lane(k); st[k] = ST_DONE;
                    end else if (g[k]) begin
                        bus.i_req_valid[k] = 1'b0; bus.i_req_last[k] = 1'b0;
                        if (ph_mode[k] == M_ABORT) begin zero_lane(k); st[k] = ST_DONE; end
                        else if (ph_mode[k] == M_STALL) seen[k] = 1'b1;
                        else st[k] = ST_SEND;
                    end
                end
                if (st[k] == ST_SEND) begin
                    nb = (ph_mode[k] == M_UNDER) ? ph_und[k] : ph_len[k];
                    if (idx[k] < nb) begin
                        bus.i_req_valid[k] = 1'b1;
                        bus.i_req_data[k*8 +: 8] = 8'(ph_base[k] + idx[k]);
                        bus.i_req_last[k] = (ph_mode[k] != M_UNDER) && (idx[k] == nb - 1);
                        idx[k]++;
                        if (rst_at > 0 && idx[k] == rst_at) begin
                            #2 rst_n = 1'b0;
                            #1;
                            chk("rst_async_valid", bus.o_gmii_tx_valid, 0);
                            chk("rst_async_data", bus.o_gmii_tx_data, 0);
                            chk("rst_async_grant", bus.o_grant, 0);
                            chk("rst_async_busy", bus.o_busy, 0);
                            chk("rst_no_pulses", mon_ov + mon_un, 0);
                            zero_inputs();
                            exp_q.delete();
                            exp_g_q.delete();
                            rr_m = 0;
                            repeat (3) @(posedge clk);
                            @(negedge clk);
                            rst_n = 1'b1;
                            mon_ov = 0; mon_un = 0;
                            return;
                        end
                    end else begin
                        if (ph_mode[k] != M_UNDER) chk("grant_release", g[k], 0);
                        zero_lane(k); st[k] = ST_DONE;
                    end
                end
            end
            all_done = 1'b1;
            for (int k = 0; k < N_REQ; k++) if (st[k] != ST_DONE) all_done = 1'b0;
        end
        if (!all_done) chk("phase_timeout", 0, 1);
        zero_inputs();
        wait_idle(IFG_CYC + WDOG_CYC + 20);
        chk("oversize_pulses", mon_ov, exp_ov);
        chk("underrun_pulses", mon_un, exp_un);
        chk("bytes_left", exp_q.size(), 0);
        chk("grants_left", exp_g_q.size(), 0);
        if (order.size() > 0) begin
            chk("first_grant_cycle", first_iter, 1);
            chk("first_grant_id", first_g, 1 << order[0]);
        end
    endtask

    task automatic zero_lane(input int k);
        bus.i_req[k] = 1'b0; bus.i_req_valid[k] = 1'b0; bus.i_req_last[k] = 1'b0;
        bus.i_req_data[k*8 +: 8] = 8'h00;
    endtask

    initial begin : stim
        logic [N_REQ-1:0] m;
        int r, l;
        zero_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_grant", bus.o_grant, 0);
        chk("reset_valid", bus.o_gmii_tx_valid, 0);
        chk("reset_data", bus.o_gmii_tx_data, 0);
        chk("reset_busy", bus.o_busy, 0);
        chk("reset_err_ov", bus.o_err_oversize, 0);
        chk("reset_err_un", bus.o_err_underrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_frame(2, M_NORM, 60, 0, 0);
        run_phase(3'b100, 1'b0, 0);
        for (int k = 0; k < N_REQ; k++) set_frame(k, M_NORM, 10, 0, 16 * (k + 1));
        run_phase(3'b111, 1'b1, 0);
        set_frame(0, M_OVER, 1600, 0, $urandom_range(0, 255));
        run_phase(3'b001, 1'b0, 0);
        set_frame(1, M_UNDER, 40, 20, $urandom_range(0, 255));
        set_frame(2, M_NORM, 5, 0, $urandom_range(0, 255));
        run_phase(3'b110, 1'b1, 0);

        repeat (40) begin
            m = 3'($urandom_range(1, 7));
            for (int k = 0; k < N_REQ; k++) begin
                r = $urandom_range(0, 99);
                l = $urandom_range(1, 80);
                if (r < 65 || (r < 80 && l < 2)) set_frame(k, M_NORM, l, 0, $urandom_range(0, 255));
                else if (r < 80) set_frame(k, M_UNDER, l, $urandom_range(1, l - 1), $urandom_range(0, 255));
                else if (r < 94 || n_over >= 2) set_frame(k, M_ABORT, l, 0, 0);
                else begin
                    if (m[k]) n_over++;
                    set_frame(k, M_OVER, $urandom_range(MAX_LEN + 1, MAX_LEN + 60), 0, $urandom_range(0, 255));
                end
            end
            run_phase(m, 1'b1, 0);
        end

        set_frame(0, M_NORM, 200, 0, $urandom_range(0, 255));
        run_phase(3'b001, 1'b0, 100);
        set_frame(0, M_NORM, 30, 0, $urandom_range(0, 255));
        run_phase(3'b001, 1'b1, 0);
`ifdef ARB_WDOG_EN
        set_frame(1, M_STALL, 1, 0, 0);
        set_frame(2, M_NORM, 20, 0, $urandom_range(0, 255));
        run_phase(3'b110, 1'b0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : guard
        #1ms;
        $display("FAIL global_timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "global timeout");
    end
endmodule
